// File: rtl/rocache_pkg.sv
// rtl/rocache_pkg.sv - shared types and helpers for the read-only instruction cache
// Purpose: FSM state type, default geometry, address-split width helpers and
//          the line-base helper shared by ro_icache and its sub-module.
// Ports:   none (package)
package rocache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FILL  = 2'd2
   } state_t;

   localparam int DEF_WORD_SIZE = 32;
   localparam int DEF_LINES     = 8;
   localparam int DEF_CNT_W     = 16;

   // Widest word address line_base() accepts; callers cast in and out.
   localparam int MAX_W = 64;

   // Line index width: one line per LINES entry.
   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Tag width: whatever remains after the index and the word-in-line bit.
   function automatic int tag_w(input int word_size, input int lines);
      return word_size - $clog2(lines) - 1;
   endfunction

   // Base word address of the 2-word line holding addr.
   function automatic logic [MAX_W-1:0] line_base(input logic [MAX_W-1:0] addr);
      return addr & ~MAX_W'(1);
   endfunction

endpackage

// File: rtl/ro_icache_sat_counter.sv
// rtl/ro_icache_sat_counter.sv - saturating event counter
// Purpose: counts cycles with inc=1, sticking at all-ones instead of wrapping.
// Ports:   Clk   rising-edge clock
//          Rst   synchronous active-high reset, clears count
//          inc   count this cycle
//          count current value
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ro_icache.sv
// rtl/ro_icache.sv - direct-mapped read-only instruction cache in front of ROMEM
// Purpose: hits return a word combinationally; a miss stalls fetch, pulls one
//          2-word line from ROMEM, fills it and lets fetch look up again.
// Ports:   Clk, Rst        clock, synchronous active-high reset
//          if_req/if_addr  fetch request and word address
//          if_data         fetched word (valid when if_req=1 and if_stall=0)
//          if_stall        fetch must hold and wait
//          flush           invalidate all lines
//          mem_address     line base word address sent to ROMEM
//          mem_enable      ROMEM enable
//          mem_data_ready  ROMEM data-ready
//          mem_data        ROMEM line: upper half = word base+1, lower = word base
//          hit_cnt         saturating count of hit cycles
//          miss_cnt        saturating count of misses
module ro_icache
   import rocache_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int LINES     = DEF_LINES,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   if_req,
   input  logic [WORD_SIZE-1:0]   if_addr,
   output logic [WORD_SIZE-1:0]   if_data,
   output logic                   if_stall,
   input  logic                   flush,
   output logic [WORD_SIZE-1:0]   mem_address,
   output logic                   mem_enable,
   input  logic                   mem_data_ready,
   input  logic [2*WORD_SIZE-1:0] mem_data,
   output logic [CNT_W-1:0]       hit_cnt,
   output logic [CNT_W-1:0]       miss_cnt
);

   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(WORD_SIZE, LINES);

   state_t state, state_nx;

   logic [LINES-1:0]       valid;
   logic [TAG_W-1:0]       tag_mem  [LINES];
   logic [2*WORD_SIZE-1:0] data_mem [LINES];
   logic                   stale;

   logic                   req_off;
   logic [IDX_W-1:0]       req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic [IDX_W-1:0]       fill_idx;
   logic [TAG_W-1:0]       fill_tag;
   logic [WORD_SIZE-1:0]   req_base;
   logic [2*WORD_SIZE-1:0] rd_line;
   logic                   hit;
   logic                   miss;
   logic                   hit_inc;
   logic                   miss_inc;
   logic                   fill_write;

   assign req_off  = if_addr[0];
   assign req_idx  = if_addr[IDX_W:1];
   assign req_tag  = if_addr[WORD_SIZE-1:IDX_W+1];
   assign req_base = WORD_SIZE'(line_base(MAX_W'(if_addr)));

   // The refill target comes from the latched line address, so fetch may
   // wander during the miss without corrupting the fill.
   assign fill_idx = mem_address[IDX_W:1];
   assign fill_tag = mem_address[WORD_SIZE-1:IDX_W+1];

   assign rd_line    = data_mem[req_idx];
   assign hit        = (state == IDLE) && if_req && valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign miss       = (state == IDLE) && if_req && !hit;
   assign fill_write = (state == FETCH) && mem_data_ready;

   // Registered-state decode only, so the ROMEM enable never glitches.
   assign mem_enable = (state == FETCH);

   always_comb begin
      state_nx = state;
      if_stall = 1'b0;
      if_data  = '0;
      hit_inc  = 1'b0;
      miss_inc = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               if_data = req_off ? rd_line[2*WORD_SIZE-1:WORD_SIZE] : rd_line[WORD_SIZE-1:0];
               hit_inc = 1'b1;
            end else if (miss) begin
               if_stall = 1'b1;
               miss_inc = 1'b1;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            if_stall = 1'b1;
            if (mem_data_ready) begin
               state_nx = FILL;
            end
         end
         FILL: begin
            // One enable-low cycle lets ROMEM drop its count and data-ready.
            if_stall = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (Rst) begin
         if_stall = 1'b0;
         if_data  = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= IDLE;
         valid       <= '0;
         stale       <= 1'b0;
         mem_address <= '0;
      end else begin
         state <= state_nx;
         if (miss) begin
            mem_address <= req_base;
         end
         // A flush while a refill is in flight marks that refill as stale so
         // it lands without becoming visible; FILL always returns to IDLE.
         if (state == FILL) begin
            stale <= 1'b0;
         end else if (flush && (state == FETCH)) begin
            stale <= 1'b1;
         end
         if (flush) begin
            valid <= '0;
         end else if (fill_write && !stale) begin
            valid[fill_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst && fill_write) begin
         data_mem[fill_idx] <= mem_data;
         tag_mem[fill_idx]  <= fill_tag;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .inc   (hit_inc),
      .count (hit_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .inc   (miss_inc),
      .count (miss_cnt)
   );

endmodule

// File: tb/tb_ro_icache.sv
// tb/tb_ro_icache.sv - bench for ro_icache with a ROMEM model
module tb_ro_icache;

   localparam int W     = 32;
   localparam int LINES = 8;
   localparam int IDX_W = 3;
   localparam int D     = 2;

   logic           Clk;
   logic           Rst;
   logic           if_req;
   logic [W-1:0]   if_addr;
   logic           flush;
   logic           mem_data_ready;
   logic [2*W-1:0] mem_data;

   logic [W-1:0]   if_data,     s_if_data;
   logic           if_stall,    s_if_stall;
   logic [W-1:0]   mem_address, s_mem_address;
   logic           mem_enable,  s_mem_enable;
   logic [15:0]    hit_cnt,     miss_cnt;
   logic [3:0]     s_hit_cnt,   s_miss_cnt;

   int checks;
   int failures;

   bit          m_valid [LINES];
   logic [31:0] m_tag   [LINES];
   int          m_hits;
   int          m_misses;

   ro_icache #(.WORD_SIZE(W), .LINES(LINES), .CNT_W(16)) u_dut (
      .Clk(Clk), .Rst(Rst), .if_req(if_req), .if_addr(if_addr),
      .if_data(if_data), .if_stall(if_stall), .flush(flush),
      .mem_address(mem_address), .mem_enable(mem_enable),
      .mem_data_ready(mem_data_ready), .mem_data(mem_data),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // Same stimulus, narrow counters; behaves identically so shares the ROMEM.
   ro_icache #(.WORD_SIZE(W), .LINES(LINES), .CNT_W(4)) u_sat (
      .Clk(Clk), .Rst(Rst), .if_req(if_req), .if_addr(if_addr),
      .if_data(s_if_data), .if_stall(s_if_stall), .flush(flush),
      .mem_address(s_mem_address), .mem_enable(s_mem_enable),
      .mem_data_ready(mem_data_ready), .mem_data(mem_data),
      .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ROMEM: word i holds 0x1000+i; data-ready rises D+1 enabled edges in and
   // stays high until enable drops.
   int rom_cnt;
   always @(posedge Clk) begin
      if (!mem_enable) begin
         rom_cnt        <= 0;
         mem_data_ready <= 1'b0;
      end else begin
         rom_cnt <= rom_cnt + 1;
         if (rom_cnt + 1 >= D + 1) begin
            mem_data_ready <= 1'b1;
            mem_data       <= {32'h1000 + mem_address + 32'd1, 32'h1000 + mem_address};
         end
      end
   end

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic model_clear_all();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic do_reset();
      Rst    = 1'b1;
      if_req = 1'b0;
      flush  = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b0;
      model_clear_all();
   endtask

   // One fetch: hold the request until the word comes back. fl>0 pulses
   // flush at that stalled cycle (1 = the miss cycle itself).
   task automatic do_access(input logic [31:0] addr, input int fl);
      int  idx, exp_m, stalls, en;
      bit  done;
      logic [31:0] tag;
      idx   = int'((addr >> 1) % LINES);
      tag   = addr >> (IDX_W + 1);
      if (m_valid[idx] && m_tag[idx] == tag) exp_m = 0;
      else if (fl >= 2 && fl <= D + 4)       exp_m = 2;
      else                                   exp_m = 1;
      if_addr = addr;
      if_req  = 1'b1;
      stalls  = 0;
      en      = 0;
      done    = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge Clk);
         if (!if_stall) begin
            done = 1'b1;
            checks++;
            if (if_data !== 32'h1000 + addr) begin
               failures++;
               $display("FAIL if_data addr=%0h: got %0h expected %0h", addr, if_data, 32'h1000 + addr);
            end
         end else begin
            stalls++;
            if (mem_enable) en++;
            if (stalls == 2) begin
               checks++;
               if (mem_address !== (addr & ~32'h1)) begin
                  failures++;
                  $display("FAIL mem_address addr=%0h: got %0h expected %0h", addr, mem_address, addr & ~32'h1);
               end
            end
            if (stalls == fl) flush = 1'b1;
         end
         @(posedge Clk); #1;
         flush = 1'b0;
      end
      if_req = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL access_timeout addr=%0h: got stalled expected data", addr);
      end
      checks++;
      if (stalls != exp_m * (D + 4)) begin
         failures++;
         $display("FAIL stall_cycles addr=%0h: got %0d expected %0d", addr, stalls, exp_m * (D + 4));
      end
      checks++;
      if (en != exp_m * (D + 2)) begin
         failures++;
         $display("FAIL enable_cycles addr=%0h: got %0d expected %0d", addr, en, exp_m * (D + 2));
      end
      if (exp_m != 0 && fl >= 1) begin
         for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_misses    += exp_m;
      m_hits      += 1;
      @(negedge Clk);
      checks += 4;
      if (hit_cnt !== 16'(m_hits)) begin
         failures++;
         $display("FAIL hit_cnt: got %0d expected %0d", hit_cnt, m_hits);
      end
      if (miss_cnt !== 16'(m_misses)) begin
         failures++;
         $display("FAIL miss_cnt: got %0d expected %0d", miss_cnt, m_misses);
      end
      if (s_hit_cnt !== 4'(sat15(m_hits))) begin
         failures++;
         $display("FAIL sat_hit_cnt: got %0d expected %0d", s_hit_cnt, sat15(m_hits));
      end
      if (s_miss_cnt !== 4'(sat15(m_misses))) begin
         failures++;
         $display("FAIL sat_miss_cnt: got %0d expected %0d", s_miss_cnt, sat15(m_misses));
      end
      @(posedge Clk); #1;
   endtask

   task automatic idle_flush();
      flush = 1'b1;
      @(posedge Clk); #1;
      flush = 1'b0;
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
   endtask

   task automatic test_reset();
      Rst     = 1'b1;
      if_req  = 1'b1;
      if_addr = 32'h4;
      flush   = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      checks += 6;
      if (if_stall !== 1'b0)     begin failures++; $display("FAIL reset_if_stall: got %0b expected 0", if_stall); end
      if (if_data !== '0)        begin failures++; $display("FAIL reset_if_data: got %0h expected 0", if_data); end
      if (mem_enable !== 1'b0)   begin failures++; $display("FAIL reset_mem_enable: got %0b expected 0", mem_enable); end
      if (mem_address !== '0)    begin failures++; $display("FAIL reset_mem_address: got %0h expected 0", mem_address); end
      if (hit_cnt !== 16'd0)     begin failures++; $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); end
      if (miss_cnt !== 16'd0)    begin failures++; $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); end
      @(posedge Clk); #1;
      Rst    = 1'b0;
      if_req = 1'b0;
      model_clear_all();
   endtask

   task automatic test_cold_miss_and_hit();
      do_reset();
      do_access(32'h4, 0);
      do_access(32'h5, 0);
   endtask

   task automatic test_conflict();
      do_access(32'h14, 0);
      do_access(32'h4, 0);
      do_access(32'h15, 0);
   endtask

   task automatic test_flush_in_fetch();
      do_reset();
      do_access(32'h14, 3);
      do_access(32'h14, 0);
   endtask

   task automatic test_rst_mid_fetch();
      do_reset();
      do_access(32'h4, 0);
      if_addr = 32'h20;
      if_req  = 1'b1;
      @(negedge Clk);
      @(posedge Clk); #1;
      @(negedge Clk);
      checks++;
      if (mem_enable !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_fetch_enable: got %0b expected 1", mem_enable);
      end
      @(posedge Clk); #1;
      @(negedge Clk);
      Rst    = 1'b1;
      if_req = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b0;
      model_clear_all();
      @(negedge Clk);
      checks += 4;
      if (mem_enable !== 1'b0) begin failures++; $display("FAIL rstmid_mem_enable: got %0b expected 0", mem_enable); end
      if (if_stall !== 1'b0)   begin failures++; $display("FAIL rstmid_if_stall: got %0b expected 0", if_stall); end
      if (hit_cnt !== 16'd0)   begin failures++; $display("FAIL rstmid_hit_cnt: got %0d expected 0", hit_cnt); end
      if (miss_cnt !== 16'd0)  begin failures++; $display("FAIL rstmid_miss_cnt: got %0d expected 0", miss_cnt); end
      @(posedge Clk); #1;
      do_access(32'h4, 0);
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 21; i++) do_access((i % 2 == 0) ? 32'h4 : 32'h5, 0);
      checks += 2;
      if (s_hit_cnt !== 4'd15) begin failures++; $display("FAIL sat_final_hit: got %0d expected 15", s_hit_cnt); end
      if (hit_cnt !== 16'd21)  begin failures++; $display("FAIL wide_final_hit: got %0d expected 21", hit_cnt); end
   endtask

   task automatic test_random();
      int fl;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) idle_flush();
         fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D + 4)) : 0;
         do_access(32'($urandom_range(0, 47)), fl);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      Rst      = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      flush    = 1'b0;
      @(posedge Clk); #1;
      test_reset();
      test_cold_miss_and_hit();
      test_conflict();
      test_flush_in_fetch();
      test_rst_mid_fetch();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
